noc_pio_in_edge: RTL

NOC_PIO_IN_EDGE -- requirements
Module: noc_pio_in_edge

---
 rtl/noc_pio_in_edge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/noc_pio_in_edge.sv
// Edge-capturing parallel input port with an Avalon-MM slave interface.
// Input pins are synchronised, per-bit edges are latched into a W1C capture
// register that drives a maskable level interrupt, and every change of the
// synchronised value is logged into a small snapshot FIFO read via address 3.
module noc_pio_in_edge #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int EDGE_MODE  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [DATA_W-1:0] in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] meta_q, sync_q, prev_q;
   logic [DATA_W-1:0] chg, edge_ev, clr_mask;
   logic [DATA_W-1:0] irq_mask, edge_cap;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              overflow;
   logic              empty, full, push, pop, push_ok, ovf_set, ovf_clr;
   logic [31:0]       status_word, rd_mux;
   logic              unused_ok;

   // Only the low DATA_W bits and bit 10 of writedata carry meaning.
   assign unused_ok = &{1'b0, writedata};

   // Two-flop synchroniser followed by a one-cycle history stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= in_port;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign chg = sync_q ^ prev_q;

   generate
      if (EDGE_MODE == 0) begin : g_rise
         assign edge_ev = chg & sync_q;
      end else if (EDGE_MODE == 1) begin : g_fall
         assign edge_ev = chg & ~sync_q;
      end else begin : g_any
         assign edge_ev = chg;
      end
   endgenerate

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign pop     = read && (address == 3'd3) && !empty;
   assign push    = |chg;
   // A push into a full FIFO only lands if a pop frees the slot this cycle.
   assign push_ok = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign ovf_clr = write && (address == 3'd4) && writedata[10];
   assign clr_mask = (write && (address == 3'd2)) ? writedata[DATA_W-1:0] : '0;

   // Interrupt is a pure function of registered state.
   assign irq = |(edge_cap & irq_mask);

   // Mask register and W1C edge capture; a new edge beats a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (write && (address == 3'd1)) irq_mask <= writedata[DATA_W-1:0];
         edge_cap <= (edge_cap & ~clr_mask) | edge_ev;
      end
   end

   // Snapshot storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= sync_q;
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         overflow <= ovf_set | (overflow & ~ovf_clr);
      end
   end

   // Status word assembled from pre-update FIFO state.
   always_comb begin
      status_word         = '0;
      status_word[CW-1:0] = count;
      status_word[8]      = empty;
      status_word[9]      = full;
      status_word[10]     = overflow;
   end

   // Register read multiplexer.
   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0: rd_mux[DATA_W-1:0] = sync_q;
         3'd1: rd_mux[DATA_W-1:0] = irq_mask;
         3'd2: rd_mux[DATA_W-1:0] = edge_cap;
         3'd3: if (!empty) rd_mux[DATA_W-1:0] = mem[rd_ptr];
         3'd4: rd_mux = status_word;
         default: rd_mux = '0;
      endcase
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else if (read) readdata <= rd_mux;
   end

endmodule
